// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage and the data memory.
// The master issues requests and consumes responses; the slave is the memory.
interface data_mem_lsu_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-lane data memory with store lane steering, load extraction/extension and
// misalignment detection behind a valid/ready request with a one-entry response slot.
module data_mem_lsu #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_lsu_if.slave  bus
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int ROW_W = ADDR_W - OFF_W;
    localparam int DEPTH = 1 << ROW_W;

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              req_err;
    logic              rd_en;
    logic [ROW_W-1:0]  row;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  align_mask;
    logic [LANES-1:0]  lane_we;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic [DATA_W-1:0] ext;
    logic              top_bit;

    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic              uns_q;
    logic              err_q;
    logic              we_q;

    assign row           = bus.req_addr[ADDR_W-1:OFF_W];
    assign off           = bus.req_addr[OFF_W-1:0];
    assign bus.req_ready = (state == IDLE) | bus.rsp_ready;
    assign accept        = bus.req_valid & bus.req_ready;

    // An erroring request must leave the RAM untouched, so both write and read enables are gated by it.
    always_comb begin
        align_mask = OFF_W'((32'd1 << bus.req_size) - 32'd1);
        req_err    = (int'(bus.req_size) > OFF_W) | ((off & align_mask) != '0);
        lane_we    = '0;
        if (accept & bus.req_we & ~req_err) begin
            lane_we = LANES'(((32'd1 << (32'd1 << bus.req_size)) - 32'd1) << off);
        end
        rd_en    = accept & ~bus.req_we & ~req_err;
        wdata_sh = bus.req_wdata << {off, 3'b000};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = RESP;
        end else if ((state == RESP) && bus.rsp_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q <= '0;
            off_q  <= '0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
        end else if (accept) begin
            size_q <= bus.req_size;
            off_q  <= off;
            uns_q  <= bus.req_unsigned;
            err_q  <= req_err;
            we_q   <= bus.req_we;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] dout_lane;

        // Reading only on accept keeps dout frozen while a response is stalled.
        always_ff @(posedge clk) begin
            if (lane_we[i]) begin
                mem[row] <= wdata_sh[8*i +: 8];
            end
            if (rd_en) begin
                dout_lane <= mem[row];
            end
        end

        assign dout[8*i +: 8] = dout_lane;
    end

    assign shifted = dout >> {off_q, 3'b000};

    always_comb begin
        keep_mask = '0;
        top_bit   = 1'b0;
        case (size_q)
            2'd0: begin
                keep_mask[7:0] = '1;
                top_bit        = shifted[7];
            end
            2'd1: begin
                keep_mask[15:0] = '1;
                top_bit         = shifted[15];
            end
            2'd2: begin
                keep_mask[31:0] = '1;
                top_bit         = shifted[31];
            end
            default: begin
                keep_mask = '1;
                top_bit   = shifted[DATA_W-1];
            end
        endcase
        ext = (shifted & keep_mask) | ({DATA_W{top_bit & ~uns_q}} & ~keep_mask);
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) & err_q;
    assign bus.rsp_rdata = ((state == RESP) && !we_q && !err_q) ? ext : '0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a 32-bit and a 64-bit instance driven from a
// vector table, plus hand sequences for stall, burst and asynchronous reset.
module tb_data_mem_lsu;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_lsu_if #(.ADDR_W(12), .DATA_W(32)) b32 ();
    data_mem_lsu_if #(.ADDR_W(12), .DATA_W(64)) b64 ();

    data_mem_lsu #(.ADDR_W(12), .DATA_W(32), .INIT_FILE("")) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    data_mem_lsu #(.ADDR_W(12), .DATA_W(64), .INIT_FILE("")) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    typedef struct {
        bit          wide;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit wide, input bit we, input logic [1:0] size, input bit uns,
                             input logic [11:0] addr, input logic [63:0] wdata);
        if (wide) begin
            b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = size;
            b64.req_unsigned = uns; b64.req_addr = addr; b64.req_wdata = wdata;
        end else begin
            b32.req_valid = 1'b1; b32.req_we = we; b32.req_size = size;
            b32.req_unsigned = uns; b32.req_addr = addr; b32.req_wdata = wdata[31:0];
        end
    endtask

    task automatic idle_req();
        b32.req_valid = 1'b0;
        b64.req_valid = 1'b0;
    endtask

    function automatic logic [63:0] rsp_data(input bit wide);
        return wide ? b64.rsp_rdata : {32'b0, b32.rsp_rdata};
    endfunction

    // One request, then the response must be present exactly one edge after accept.
    task automatic apply_stimulus(input int idx, input vec_t v);
        int waited = 0;
        drive_req(v.wide, v.we, v.size, v.uns, v.addr, v.wdata);
        while (!(v.wide ? b64.req_ready : b32.req_ready) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d accept: req_ready never rose", idx);
        end
        @(posedge clk); #1;
        idle_req();
        check_output($sformatf("v%0d valid", idx), {63'b0, v.wide ? b64.rsp_valid : b32.rsp_valid}, 64'd1);
        check_output($sformatf("v%0d rdata", idx), rsp_data(v.wide), v.exp_rdata);
        check_output($sformatf("v%0d err", idx), {63'b0, v.wide ? b64.rsp_err : b32.rsp_err}, {63'b0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  b_size [4];
        bit          b_uns  [4];
        logic [11:0] b_addr [4];
        logic [63:0] b_exp  [4];

        // wide, we, size, uns, addr, wdata, exp_rdata, exp_err
        vecs.push_back('{0, 1, 2'd2, 0, 12'h010, 64'hDEADBEEF,         64'h0,                 0});
        vecs.push_back('{0, 0, 2'd2, 0, 12'h010, 64'h0,                64'hDEADBEEF,          0});
        vecs.push_back('{0, 1, 2'd0, 0, 12'h013, 64'h80,               64'h0,                 0});
        vecs.push_back('{0, 0, 2'd0, 0, 12'h013, 64'h0,                64'hFFFFFF80,          0});
        vecs.push_back('{0, 0, 2'd0, 1, 12'h013, 64'h0,                64'h00000080,          0});
        vecs.push_back('{0, 0, 2'd2, 0, 12'h010, 64'h0,                64'h80ADBEEF,          0});
        vecs.push_back('{0, 0, 2'd1, 0, 12'h012, 64'h0,                64'hFFFF80AD,          0});
        vecs.push_back('{0, 0, 2'd1, 0, 12'h011, 64'h0,                64'h0,                 1});
        vecs.push_back('{0, 1, 2'd2, 0, 12'h012, 64'h11223344,         64'h0,                 1});
        vecs.push_back('{0, 0, 2'd2, 0, 12'h010, 64'h0,                64'h80ADBEEF,          0});
        vecs.push_back('{0, 0, 2'd1, 1, 12'h010, 64'h0,                64'h0000BEEF,          0});
        vecs.push_back('{0, 0, 2'd0, 0, 12'h011, 64'h0,                64'hFFFFFFBE,          0});
        vecs.push_back('{0, 0, 2'd3, 0, 12'h010, 64'h0,                64'h0,                 1});
        vecs.push_back('{0, 1, 2'd2, 0, 12'h014, 64'h0,                64'h0,                 0});
        vecs.push_back('{0, 1, 2'd1, 0, 12'h016, 64'h00AB1234,         64'h0,                 0});
        vecs.push_back('{0, 1, 2'd0, 0, 12'h015, 64'hFFFFFF55,         64'h0,                 0});
        vecs.push_back('{0, 0, 2'd2, 0, 12'h014, 64'h0,                64'h12345500,          0});
        vecs.push_back('{0, 0, 2'd1, 0, 12'h016, 64'h0,                64'h00001234,          0});
        vecs.push_back('{0, 1, 2'd2, 0, 12'hFFC, 64'hCAFEF00D,         64'h0,                 0});
        vecs.push_back('{0, 0, 2'd2, 0, 12'hFFC, 64'h0,                64'hCAFEF00D,          0});
        vecs.push_back('{0, 0, 2'd1, 0, 12'hFFE, 64'h0,                64'hFFFFCAFE,          0});
        vecs.push_back('{1, 1, 2'd3, 0, 12'h008, 64'h0123456789ABCDEF, 64'h0,                 0});
        vecs.push_back('{1, 0, 2'd2, 0, 12'h00C, 64'h0,                64'h0000000001234567,  0});
        vecs.push_back('{1, 0, 2'd2, 0, 12'h008, 64'h0,                64'hFFFFFFFF89ABCDEF,  0});
        vecs.push_back('{1, 0, 2'd2, 1, 12'h008, 64'h0,                64'h0000000089ABCDEF,  0});
        vecs.push_back('{1, 0, 2'd3, 0, 12'h008, 64'h0,                64'h0123456789ABCDEF,  0});
        vecs.push_back('{1, 0, 2'd3, 0, 12'h004, 64'h0,                64'h0,                 1});
        vecs.push_back('{1, 0, 2'd0, 0, 12'h00F, 64'h0,                64'h0000000000000001,  0});
        vecs.push_back('{1, 0, 2'd2, 0, 12'h00A, 64'h0,                64'h0,                 1});
        vecs.push_back('{1, 1, 2'd0, 0, 12'h00F, 64'hFE,               64'h0,                 0});
        vecs.push_back('{1, 0, 2'd3, 0, 12'h008, 64'h0,                64'hFE23456789ABCDEF,  0});

        rst = 1'b1;
        idle_req();
        b32.req_we = 1'b0; b32.req_size = 2'd0; b32.req_unsigned = 1'b0;
        b32.req_addr = '0; b32.req_wdata = '0; b32.rsp_ready = 1'b1;
        b64.req_we = 1'b0; b64.req_size = 2'd0; b64.req_unsigned = 1'b0;
        b64.req_addr = '0; b64.req_wdata = '0; b64.rsp_ready = 1'b1;
        #12;
        check_output("reset rsp_valid", {63'b0, b32.rsp_valid}, 64'd0);
        check_output("reset rsp_err",   {63'b0, b32.rsp_err},   64'd0);
        check_output("reset rsp_rdata", rsp_data(1'b0),          64'd0);
        check_output("reset req_ready", {63'b0, b32.req_ready}, 64'd1);
        check_output("reset rsp_valid64", {63'b0, b64.rsp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) apply_stimulus(i, vecs[i]);
        @(posedge clk); #1;

        // Stall: response must hold for three cycles while the consumer is busy.
        b32.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
        @(posedge clk); #1;
        idle_req();
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("stall%0d valid", k), {63'b0, b32.rsp_valid}, 64'd1);
            check_output($sformatf("stall%0d rdata", k), rsp_data(1'b0), 64'h80ADBEEF);
            check_output($sformatf("stall%0d req_ready", k), {63'b0, b32.req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        b32.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_output("stall drain valid", {63'b0, b32.rsp_valid}, 64'd0);

        // Burst: four loads accepted back to back, responses on consecutive cycles.
        b_size = '{2'd2, 2'd0, 2'd2, 2'd1};
        b_uns  = '{1'b0, 1'b1, 1'b0, 1'b1};
        b_addr = '{12'h010, 12'h013, 12'h014, 12'h016};
        b_exp  = '{64'h80ADBEEF, 64'h80, 64'h12345500, 64'h1234};
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b0, 1'b0, b_size[k], b_uns[k], b_addr[k], 64'h0);
            check_output($sformatf("burst%0d req_ready", k), {63'b0, b32.req_ready}, 64'd1);
            @(posedge clk); #1;
            check_output($sformatf("burst%0d valid", k), {63'b0, b32.rsp_valid}, 64'd1);
            check_output($sformatf("burst%0d rdata", k), rsp_data(1'b0), b_exp[k]);
        end
        idle_req();
        @(posedge clk); #1;
        check_output("burst end valid", {63'b0, b32.rsp_valid}, 64'd0);

        // Asynchronous reset while a stalled load response is pending.
        b32.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 2'd2, 1'b0, 12'h014, 64'h0);
        @(posedge clk); #1;
        idle_req();
        check_output("prereset valid", {63'b0, b32.rsp_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async rst valid",     {63'b0, b32.rsp_valid}, 64'd0);
        check_output("async rst rdata",     rsp_data(1'b0),          64'd0);
        check_output("async rst err",       {63'b0, b32.rsp_err},   64'd0);
        check_output("async rst req_ready", {63'b0, b32.req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        b32.rsp_ready = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(100, '{0, 0, 2'd2, 0, 12'h010, 64'h0, 64'h80ADBEEF, 0});
        apply_stimulus(101, '{1, 0, 2'd3, 0, 12'h008, 64'h0, 64'hFE23456789ABCDEF, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
